// File: rtl/mem_access_unit_if.sv
// Bundles the pipeline-side request signals and the data-memory bus of the load/store unit.
// The master modport is the unit's view; slave is the pipeline/memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data_out;
  logic        done;
  logic        fault;
  logic        stall;

  modport master (
    input  req_valid, is_load, is_store, funct3, addr, store_data, mem_ready, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           load_data_out, done, fault, stall
  );

  modport slave (
    output req_valid, is_load, is_store, funct3, addr, store_data, mem_ready, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           load_data_out, done, fault, stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory-stage load/store unit: validates and formats an access, runs the
// data-memory handshake with a timeout, and extends load data for MEM/WB.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.master bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
  logic [2:0]         r_funct3;
  logic [1:0]         r_lane;
  logic               r_is_load;

  logic               w_accept, w_illegal, w_timeout;
  logic [DATA_W-1:0]  w_fmt_wdata, w_ext_data;
  logic [3:0]         w_fmt_wstrb;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;

  logic               w_req_d, w_we_d, w_done_d, w_fault_d, w_ready_d;
  logic [DATA_W-1:0]  w_addr_d, w_wdata_d, w_ldata_d;
  logic [3:0]         w_wstrb_d;

  logic               r_mem_req, r_mem_we, r_done, r_fault, r_req_ready, r_stall;
  logic [DATA_W-1:0]  r_mem_addr, r_mem_wdata, r_load_data;
  logic [3:0]         r_mem_wstrb;

  assign w_accept  = bus.req_valid & (bus.is_load | bus.is_store);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

  // Illegal: both flags, unsupported width code, or misaligned address.
  always_comb begin
    w_illegal = 1'b0;
    if (bus.is_load && bus.is_store)                          w_illegal = 1'b1;
    if (bus.funct3[1:0] == 2'b11)                             w_illegal = 1'b1;
    if (bus.funct3 == 3'b110)                                 w_illegal = 1'b1;
    if (bus.is_store && bus.funct3[2])                        w_illegal = 1'b1;
    if (bus.funct3[1:0] == 2'b01 && bus.addr[0])              w_illegal = 1'b1;
    if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)   w_illegal = 1'b1;
  end

  always_comb begin
    w_fmt_wdata = bus.store_data;
    w_fmt_wstrb = 4'b1111;
    case (bus.funct3[1:0])
      2'b00: begin
        w_fmt_wdata = {4{bus.store_data[7:0]}};
        w_fmt_wstrb = 4'b0001 << bus.addr[1:0];
      end
      2'b01: begin
        w_fmt_wdata = {2{bus.store_data[15:0]}};
        w_fmt_wstrb = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext_data = {24'd0, w_byte};
      3'b001:  w_ext_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext_data = {16'd0, w_half};
      default: w_ext_data = bus.mem_rdata;
    endcase
  end

  // State register plus the request fields latched on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_lane    <= '0;
      r_is_load <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_d;
      if (r_state == S_IDLE && w_accept) begin
        r_funct3  <= bus.funct3;
        r_lane    <= bus.addr[1:0];
        r_is_load <= bus.is_load;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_illegal ? S_RESP : S_ACCESS;
      S_ACCESS: if (bus.mem_ready || w_timeout) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields are zero unless a request is live.
  always_comb begin
    w_req_d   = 1'b0;
    w_we_d    = 1'b0;
    w_addr_d  = '0;
    w_wdata_d = '0;
    w_wstrb_d = '0;
    w_ldata_d = '0;
    w_done_d  = 1'b0;
    w_fault_d = 1'b0;
    w_cnt_d   = '0;
    w_ready_d = (w_next == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_illegal) begin
          w_done_d  = 1'b1;
          w_fault_d = 1'b1;
        end else if (w_accept) begin
          w_req_d  = 1'b1;
          w_we_d   = bus.is_store;
          w_addr_d = {bus.addr[31:2], 2'b00};
          if (bus.is_store) begin
            w_wdata_d = w_fmt_wdata;
            w_wstrb_d = w_fmt_wstrb;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          w_done_d  = 1'b1;
          w_ldata_d = r_is_load ? w_ext_data : '0;
        end else if (w_timeout) begin
          w_done_d  = 1'b1;
          w_fault_d = 1'b1;
        end else begin
          w_req_d   = 1'b1;
          w_we_d    = r_mem_we;
          w_addr_d  = r_mem_addr;
          w_wdata_d = r_mem_wdata;
          w_wstrb_d = r_mem_wstrb;
          w_cnt_d   = w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_load_data <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_req_ready <= 1'b1;
      r_stall     <= 1'b0;
    end else begin
      r_mem_req   <= w_req_d;
      r_mem_we    <= w_we_d;
      r_mem_addr  <= w_addr_d;
      r_mem_wdata <= w_wdata_d;
      r_mem_wstrb <= w_wstrb_d;
      r_load_data <= w_ldata_d;
      r_done      <= w_done_d;
      r_fault     <= w_fault_d;
      r_req_ready <= w_ready_d;
      r_stall     <= ~w_ready_d;
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wstrb     = r_mem_wstrb;
  assign bus.load_data_out = r_load_data;
  assign bus.done          = r_done;
  assign bus.fault         = r_fault;
  assign bus.req_ready     = r_req_ready;
  assign bus.stall         = r_stall;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline.
- Sits directly upstream of the MEM/WB pipeline register. It takes the execute-stage address, store data and funct3, and runs a request/ready handshake with data memory.
- For loads, it aligns and sign/zero-extends the memory word into the 32-bit load data that the MEM/WB register captures.
- It holds the pipeline stalled while an access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready before aborting with fault (range 1..255).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents an access this cycle.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- is_load  in  1  access is a load.
- is_store  in  1  access is a store.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address from ALU.
- store_data  in  32  rs2 value for stores.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  replicated store data.
- mem_wstrb  out  4  byte enables; 0000 for reads.
- mem_ready  in  1  memory completes the access this cycle; mem_rdata valid when high.
- mem_rdata  in  32  read word.
- load_data_out  out  32  extended load result; valid while done=1.
- done  out  1  one-cycle pulse: access finished (success or fault).
- fault  out  1  one-cycle pulse coincident with done: misaligned, illegal funct3, load+store, or timeout.
- stall  out  1  high whenever the unit is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter=0.
  - mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr, load_data_out, done and fault all 0.
  - req_ready=1, stall=0.
  - Reset mid-access drops mem_req immediately; no done is generated for the aborted access.
- States:
  - IDLE: accept when req_valid & (is_load|is_store). Requests with neither flag set are ignored (no done).
  - ACCESS: mem_req=1 with latched fields held stable until mem_ready.
  - RESP: done=1 for exactly one cycle, then IDLE.
- Accept in IDLE, legal request: latch funct3, addr[1:0] and store data; drive mem_* from registers; go to ACCESS.
- Accept in IDLE, illegal request: go directly to RESP with fault=1, load_data_out=0, and no mem_req. Illegal means any of:
  - is_load & is_store;
  - funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00.
- ACCESS:
  - Counter increments each cycle.
  - mem_ready=1 → capture, go to RESP with fault=0.
  - Counter reaches TIMEOUT with mem_ready=0 → deassert mem_req, go to RESP with fault=1, load_data_out=0.
  - mem_ready takes priority if it arrives on the TIMEOUT cycle.
- Latency: accept edge at cycle 0; mem_req high in cycle 1; mem_ready in cycle 1 gives done in cycle 2. Minimum 2 cycles; a fault on accept gives done in cycle 1.
- Load extraction (byte lane = addr[1:0], half = addr[1]):
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half.
  - LHU: zero-extend half.
  - LW: whole word.
  - The result is registered into load_data_out on the mem_ready cycle.
- Store formatting:
  - SB: wdata = {4{store_data[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{store_data[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = store_data, wstrb = 1111.
  - Stores leave load_data_out=0 at done.
- req_ready = (state==IDLE); stall = ~req_ready. New requests are not accepted during RESP.
- mem_we/mem_wstrb/mem_wdata are zero whenever mem_req=0.

Test Plan:
- LB addr=0x00001003, mem_rdata=0x80FF1234, mem_ready in cycle 1 → mem_addr=0x00001000, wstrb=0000, done cycle 2, load_data_out=0xFFFFFF80, fault=0.
- LHU addr=0x00001002, mem_rdata=0x80FF1234 → load_data_out=0x000080FF; LH same → 0xFFFF80FF.
- SB addr=0x00002001, store_data=0x123456AB → mem_we=1, mem_addr=0x00002000, wdata=0xABABABAB, wstrb=0010; SH addr=0x2002 → wstrb=1100.
- LW addr=0x00001002 → no mem_req ever, done=1 and fault=1 in cycle 1, load_data_out=0; req_ready back to 1 in cycle 2.
- LW with mem_ready held 0 → mem_req high for exactly 16 cycles, then done=1 and fault=1, stall=1 throughout until return to IDLE.
- rst_n pulled low in cycle 3 of ACCESS → mem_req=0 and stall=0 asynchronously, no done pulse; a fresh LW after release completes normally.
